// File: rtl/endian_bridge_arbiter_pkg.sv
// Shared definitions for the endianness-bridge front end: default AXIS widths and helpers.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package endian_bridge_arbiter_pkg;

    localparam int DEF_AXIS_DATA_WIDTH  = 64;
    localparam int DEF_AXIS_TUSER_WIDTH = 128;
    localparam int DEF_NUM_QUEUES       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    // Ceiling log2, never less than 1 so a 1-bit index is still a legal vector.
    function automatic int log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry in-order register FIFO; head entry drives the downstream bus directly from flops.
// Latency: 1 cycle from push to head when empty; 1 beat/cycle sustained with head_rdy high.
// Backpressure: full comes from registered occupancy only, so upstream ready has no path from head_rdy.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int USER_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic [KEEP_WIDTH-1:0] push_keep,
    input  logic [USER_WIDTH-1:0] push_user,
    input  logic                  push_last,
    input  logic                  head_rdy,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic [KEEP_WIDTH-1:0] head_keep,
    output logic [USER_WIDTH-1:0] head_user,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    localparam int EW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [EW-1:0] ent0;
    logic [EW-1:0] ent1;
    logic [EW-1:0] push_ent;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    assign push_ent = {push_last, push_user, push_keep, push_dat};
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    // A push offered while full is dropped here; the arbiter never offers one.
    assign push     = push_vld && !full;
    assign pop      = !empty && head_rdy;

    assign {head_last, head_user, head_keep, head_dat} = ent0;

    // Occupancy and entry update; ent0 is always the head so outputs stay registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        ent0  <= push_ent;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0 <= push_ent;
                    end else if (push) begin
                        ent1  <= push_ent;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0  <= ent1;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/endian_bridge_arbiter.sv
// Packet-granular round-robin arbiter feeding one endianness bridge from NUM_QUEUES AXIS sources.
// Latency: one arbitration bubble per packet, then 1 cycle source-to-bridge through the skid buffer.
// Backpressure: only the granted queue sees ready, equal to ~skid_full; grant held until tlast is accepted.
module endian_bridge_arbiter
    import endian_bridge_arbiter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = DEF_AXIS_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = DEF_AXIS_TUSER_WIDTH,
    parameter int NUM_QUEUES         = DEF_NUM_QUEUES,
    parameter int NUM_QUEUES_WIDTH   = log2(NUM_QUEUES)
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                   s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                   s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                   s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast,
    output logic [NUM_QUEUES_WIDTH-1:0]             grant_idx,
    output logic                                    busy
);

    localparam int W  = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int QW = NUM_QUEUES_WIDTH;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [QW-1:0] grant_nxt;
    logic [QW-1:0] rr_ptr;
    logic [QW-1:0] rr_ptr_nxt;
    logic [QW-1:0] sel_idx;
    logic [QW-1:0] cand;
    logic          sel_vld;

    logic [W-1:0]  g_tdata;
    logic [KW-1:0] g_tkeep;
    logic [UW-1:0] g_tuser;
    logic          g_tvalid;
    logic          g_tlast;

    logic          skid_full;
    logic          skid_empty;
    logic          beat_acc;

    // Rotating-priority search: first valid queue starting just after the last winner.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            cand = QW'((int'(rr_ptr) + i) % NUM_QUEUES);
            if (!sel_vld && s_axis_tvalid[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Select the granted queue's beat; the payload is passed through untouched.
    always_comb begin
        g_tdata  = '0;
        g_tkeep  = '0;
        g_tuser  = '0;
        g_tvalid = 1'b0;
        g_tlast  = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (grant_idx == QW'(q)) begin
                g_tdata  = s_axis_tdata[q*W +: W];
                g_tkeep  = s_axis_tkeep[q*KW +: KW];
                g_tuser  = s_axis_tuser[q*UW +: UW];
                g_tvalid = s_axis_tvalid[q];
                g_tlast  = s_axis_tlast[q];
            end
        end
    end

    assign beat_acc = (state == ST_PKT) && g_tvalid && !skid_full;

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_ptr    <= QW'(NUM_QUEUES - 1);
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    // Next state: grant in IDLE, release after the accepted tlast beat; no preemption.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_idx;
        rr_ptr_nxt = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_nxt = ST_PKT;
                    grant_nxt = sel_idx;
                end
            end
            ST_PKT: begin
                if (beat_acc && g_tlast) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = grant_idx;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: only the granted queue sees ready, and only while the skid has room.
    always_comb begin
        s_axis_tready = '0;
        busy          = (state == ST_PKT);
        if (state == ST_PKT) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (grant_idx == QW'(q)) begin
                    s_axis_tready[q] = !skid_full;
                end
            end
        end
    end

    assign m_axis_tvalid = !skid_empty;

    axis_skid_buf #(
        .DATA_WIDTH (W),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .push_vld  (beat_acc),
        .push_dat  (g_tdata),
        .push_keep (g_tkeep),
        .push_user (g_tuser),
        .push_last (g_tlast),
        .head_rdy  (m_axis_tready),
        .head_dat  (m_axis_tdata),
        .head_keep (m_axis_tkeep),
        .head_user (m_axis_tuser),
        .head_last (m_axis_tlast),
        .full      (skid_full),
        .empty     (skid_empty)
    );

endmodule

// File: tb/tb_endian_bridge_arbiter.sv
module tb_endian_bridge_arbiter;

    localparam int W  = 64;
    localparam int K  = 8;
    localparam int U  = 128;
    localparam int NQ = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NQ*W-1:0] s_axis_tdata;
    logic [NQ*K-1:0] s_axis_tkeep;
    logic [NQ*U-1:0] s_axis_tuser;
    logic [NQ-1:0]   s_axis_tvalid;
    logic [NQ-1:0]   s_axis_tlast;
    logic [NQ-1:0]   s_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic [K-1:0]    m_axis_tkeep;
    logic [U-1:0]    m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [1:0]      grant_idx;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    endian_bridge_arbiter #(
        .C_AXIS_DATA_WIDTH  (W),
        .C_AXIS_TUSER_WIDTH (U),
        .NUM_QUEUES         (NQ),
        .NUM_QUEUES_WIDTH   (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_q(input int q, input logic v, input logic l, input logic [W-1:0] d,
                         input logic [K-1:0] k, input logic [U-1:0] u);
        s_axis_tvalid[q]        = v;
        s_axis_tlast[q]         = l;
        s_axis_tdata[q*W +: W]  = d;
        s_axis_tkeep[q*K +: K]  = k;
        s_axis_tuser[q*U +: U]  = u;
    endtask

    task automatic do_reset();
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        resetn        = 1'b0;
        tick();
        resetn        = 1'b1;
    endtask

    initial begin
        // ---- 1: reset with every queue valid, then grants 0,1,2,3,0 ----
        do_reset();
        for (int q = 0; q < NQ; q++) begin
            set_q(q, 1'b1, 1'b1, 64'hA0 + 64'(q), 8'hFF, 128'h100 + 128'(q));
        end
        resetn = 1'b0;
        tick();
        chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_s_tready", 128'(s_axis_tready), 128'd0);
        chk("rst_grant", 128'(grant_idx), 128'd0);
        chk("rst_m_tdata", 128'(m_axis_tdata), 128'd0);
        chk("rst_m_tlast", 128'(m_axis_tlast), 128'd0);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t1_grant", 128'(grant_idx), 128'(k % 4));
            chk("t1_busy", 128'(busy), 128'd1);
            if (k < 4) begin
                tick();
                chk("t1_m_tvalid", 128'(m_axis_tvalid), 128'd1);
                chk("t1_m_tdata", 128'(m_axis_tdata), 128'hA0 + 128'(k));
                chk("t1_m_tuser", m_axis_tuser, 128'h100 + 128'(k));
                chk("t1_m_tlast", 128'(m_axis_tlast), 128'd1);
            end
        end

        // ---- 2: Q1 3-beat packet holds grant while Q2 waits ----
        do_reset();
        set_q(1, 1'b1, 1'b0, 64'h1100, 8'hFF, 128'h11);
        set_q(2, 1'b1, 1'b1, 64'h2200, 8'hFF, 128'h22);
        tick();
        chk("t2_grant1", 128'(grant_idx), 128'd1);
        chk("t2_rdy_e1", 128'(s_axis_tready), 128'b0010);
        tick();
        chk("t2_beat0", 128'(m_axis_tdata), 128'h1100);
        chk("t2_rdy_e2", 128'(s_axis_tready), 128'b0010);
        set_q(1, 1'b1, 1'b0, 64'h1101, 8'hFF, 128'h11);
        tick();
        chk("t2_beat1", 128'(m_axis_tdata), 128'h1101);
        chk("t2_rdy_e3", 128'(s_axis_tready), 128'b0010);
        set_q(1, 1'b1, 1'b1, 64'h1102, 8'hFF, 128'h11);
        tick();
        chk("t2_beat2", 128'(m_axis_tdata), 128'h1102);
        chk("t2_last2", 128'(m_axis_tlast), 128'd1);
        chk("t2_idle_rdy", 128'(s_axis_tready), 128'd0);
        chk("t2_idle_busy", 128'(busy), 128'd0);
        set_q(1, 1'b0, 1'b0, 64'h0, 8'h00, 128'h0);
        tick();
        chk("t2_grant2", 128'(grant_idx), 128'd2);
        chk("t2_rdy_q2", 128'(s_axis_tready), 128'b0100);
        chk("t2_bubble", 128'(m_axis_tvalid), 128'd0);
        tick();
        chk("t2_q2_data", 128'(m_axis_tdata), 128'h2200);
        chk("t2_q2_vld", 128'(m_axis_tvalid), 128'd1);

        // ---- 3: downstream stall fills skid, no loss or duplication ----
        do_reset();
        m_axis_tready = 1'b0;
        set_q(0, 1'b1, 1'b0, 64'h3300, 8'hFF, 128'h33);
        tick();
        chk("t3_rdy_e1", 128'(s_axis_tready), 128'b0001);
        tick();
        chk("t3_vld_e2", 128'(m_axis_tvalid), 128'd1);
        chk("t3_head_e2", 128'(m_axis_tdata), 128'h3300);
        chk("t3_rdy_e2", 128'(s_axis_tready), 128'b0001);
        set_q(0, 1'b1, 1'b0, 64'h3301, 8'hFF, 128'h33);
        tick();
        chk("t3_rdy_full", 128'(s_axis_tready), 128'd0);
        chk("t3_head_e3", 128'(m_axis_tdata), 128'h3300);
        set_q(0, 1'b1, 1'b0, 64'h3302, 8'hFF, 128'h33);
        tick();
        tick();
        tick();
        chk("t3_rdy_hold", 128'(s_axis_tready), 128'd0);
        chk("t3_head_hold", 128'(m_axis_tdata), 128'h3300);
        chk("t3_vld_hold", 128'(m_axis_tvalid), 128'd1);
        m_axis_tready = 1'b1;
        tick();
        chk("t3_out_b1", 128'(m_axis_tdata), 128'h3301);
        chk("t3_rdy_back", 128'(s_axis_tready), 128'b0001);
        tick();
        chk("t3_out_b2", 128'(m_axis_tdata), 128'h3302);
        set_q(0, 1'b1, 1'b1, 64'h3303, 8'hFF, 128'h33);
        tick();
        chk("t3_out_b3", 128'(m_axis_tdata), 128'h3303);
        chk("t3_last_b3", 128'(m_axis_tlast), 128'd1);
        set_q(0, 1'b0, 1'b0, 64'h0, 8'h00, 128'h0);
        tick();
        chk("t3_drained", 128'(m_axis_tvalid), 128'd0);
        chk("t3_idle", 128'(busy), 128'd0);

        // ---- 4: only Q3 valid, four single-beat packets ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_q(3, 1'b1, 1'b1, 64'h4400 + 64'(k), 8'hFF, 128'h44);
            tick();
            chk("t4_grant", 128'(grant_idx), 128'd3);
            chk("t4_busy", 128'(busy), 128'd1);
            tick();
            chk("t4_data", 128'(m_axis_tdata), 128'h4400 + 128'(k));
            chk("t4_last", 128'(m_axis_tlast), 128'd1);
            chk("t4_vld", 128'(m_axis_tvalid), 128'd1);
            chk("t4_idle", 128'(busy), 128'd0);
        end

        // ---- 5: byte order, tkeep and tuser pass through; tkeep=0 forwarded ----
        do_reset();
        set_q(1, 1'b0, 1'b1, 64'hFFFF, 8'hFF, 128'h1);
        set_q(3, 1'b0, 1'b1, 64'hEEEE, 8'hFF, 128'h3);
        set_q(2, 1'b1, 1'b1, 64'h0706050403020100, 8'h0F, 128'h0123456789ABCDEF_FEDCBA9876543210);
        tick();
        chk("t5_grant", 128'(grant_idx), 128'd2);
        tick();
        chk("t5_tdata", 128'(m_axis_tdata), 128'h0706050403020100);
        chk("t5_tkeep", 128'(m_axis_tkeep), 128'h0F);
        chk("t5_tuser", m_axis_tuser, 128'h0123456789ABCDEF_FEDCBA9876543210);
        set_q(2, 1'b1, 1'b1, 64'hDEAD, 8'h00, 128'h5A);
        tick();
        tick();
        chk("t5_keep0_vld", 128'(m_axis_tvalid), 128'd1);
        chk("t5_keep0", 128'(m_axis_tkeep), 128'd0);
        chk("t5_keep0_dat", 128'(m_axis_tdata), 128'hDEAD);

        // ---- 6: reset mid-packet with one beat buffered ----
        do_reset();
        m_axis_tready = 1'b0;
        set_q(1, 1'b1, 1'b0, 64'h5500, 8'hFF, 128'h55);
        tick();
        tick();
        chk("t6_pre_vld", 128'(m_axis_tvalid), 128'd1);
        chk("t6_pre_busy", 128'(busy), 128'd1);
        resetn = 1'b0;
        tick();
        chk("t6_m_tvalid", 128'(m_axis_tvalid), 128'd0);
        chk("t6_busy", 128'(busy), 128'd0);
        chk("t6_s_tready", 128'(s_axis_tready), 128'd0);
        chk("t6_m_tdata", 128'(m_axis_tdata), 128'd0);
        s_axis_tvalid = '0;
        resetn = 1'b1;
        tick();
        tick();
        chk("t6_idle_stay", 128'(busy), 128'd0);
        chk("t6_idle_rdy", 128'(s_axis_tready), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
